// File: rtl/freq_meas_pkg.sv
// Shared types and default timing for the frequency-measurement scheduler.
// Defaults assume a 50 MHz system clock.
package freq_meas_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPick,
    StSettle,
    StGate,
    StPost,
    StWait,
    StOut
  } sched_state_e;

  localparam int unsigned PreCntMaxDef  = 12_499_999;
  localparam int unsigned GateCntMaxDef = 49_999_999;
  localparam int unsigned PostCntMaxDef = 12_499_999;
  localparam int unsigned TmoMaxDef     = 1_000_000;
  localparam int unsigned FreqWDef      = 30;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/freq_meas_sched_rr_pick.sv
// Combinational round-robin finder: first set bit of mask_i strictly after ptr_i,
// wrapping modulo N. any_o is low when the mask is empty.
module rr_pick #(
  parameter int unsigned N = 4,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] mask_i,
  input  logic [W-1:0] ptr_i,
  output logic [W-1:0] idx_o,
  output logic         any_o
);

  logic         found_hi;
  logic [W-1:0] idx_hi;
  logic [W-1:0] idx_lo;

  // Descending scan so the last hit is the lowest index in each half.
  always_comb begin
    found_hi = 1'b0;
    idx_hi   = '0;
    idx_lo   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (mask_i[k]) begin
        idx_lo = W'(k);
        if (W'(k) > ptr_i) begin
          idx_hi   = W'(k);
          found_hi = 1'b1;
        end
      end
    end
    idx_o = found_hi ? idx_hi : idx_lo;
    any_o = |mask_i;
  end

endmodule

// File: rtl/freq_meas_sched.sv
// Round-robin scheduler sharing one frequency-counting core across CH_NUM inputs.
// Optional macro FREQ_SCHED_TMO_EN adds a core_done timeout reported via res_err.
module freq_meas_sched
  import freq_meas_pkg::*;
#(
  parameter int unsigned CH_NUM       = 4,
  parameter int unsigned CH_W         = 2,
  parameter int unsigned PRE_CNT_MAX  = PreCntMaxDef,
  parameter int unsigned GATE_CNT_MAX = GateCntMaxDef,
  parameter int unsigned POST_CNT_MAX = PostCntMaxDef,
  parameter int unsigned FREQ_W       = FreqWDef,
  parameter int unsigned TMO_MAX      = TmoMaxDef
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              run,
  input  logic [CH_NUM-1:0] ch_en,
  output logic [CH_W-1:0]   ch_sel,
  output logic              core_clr,
  output logic              gate,
  input  logic              core_done,
  input  logic [FREQ_W-1:0] core_freq,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CH_W-1:0]   res_ch,
  output logic [FREQ_W-1:0] res_freq,
  output logic              res_err,
  output logic              busy
);

  localparam int unsigned CntMax = max_u(max_u(PRE_CNT_MAX, GATE_CNT_MAX),
                                         max_u(POST_CNT_MAX, TMO_MAX));
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  sched_state_e      state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CH_W-1:0]   ptr_q;
  logic [CH_W-1:0]   ch_sel_q;
  logic [CH_W-1:0]   res_ch_q;
  logic [FREQ_W-1:0] res_freq_q;
  logic              res_err_q;
  logic [CH_W-1:0]   pick_idx;
  logic              pick_any;
  logic              capture;
  logic              cap_err;

  rr_pick #(
    .N(CH_NUM),
    .W(CH_W)
  ) u_rr_pick (
    .mask_i(ch_en),
    .ptr_i (ptr_q),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    cap_err = 1'b0;
    unique case (state_q)
      StIdle:   if (run && (|ch_en)) state_d = StPick;
      StPick:   state_d = pick_any ? StSettle : StIdle;
      StSettle: if (cnt_q == CntW'(PRE_CNT_MAX)) state_d = StGate;
      StGate:   if (cnt_q == CntW'(GATE_CNT_MAX)) state_d = StPost;
      StPost:   if (cnt_q == CntW'(POST_CNT_MAX)) state_d = StWait;
      StWait: begin
        if (core_done) begin
          capture = 1'b1;
          state_d = StOut;
        end
`ifdef FREQ_SCHED_TMO_EN
        else if (cnt_q == CntW'(TMO_MAX - 1)) begin
          capture = 1'b1;
          cap_err = 1'b1;
          state_d = StOut;
        end
`endif
      end
      StOut:    if (res_ready) state_d = run ? StPick : StIdle;
      default:  state_d = StIdle;
    endcase
    // Shared counter restarts from zero on every state entry.
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      ptr_q      <= CH_W'(CH_NUM - 1);
      ch_sel_q   <= '0;
      res_ch_q   <= '0;
      res_freq_q <= '0;
      res_err_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (state_q == StPick && pick_any) begin
        ptr_q    <= pick_idx;
        ch_sel_q <= pick_idx;
      end
      if (capture) begin
        res_ch_q   <= ch_sel_q;
        res_freq_q <= cap_err ? '0 : core_freq;
        res_err_q  <= cap_err;
      end
    end
  end

  assign ch_sel    = ch_sel_q;
  assign core_clr  = (state_q == StPick) && pick_any;
  assign gate      = (state_q == StGate);
  assign res_valid = (state_q == StOut);
  assign res_ch    = res_ch_q;
  assign res_freq  = res_freq_q;
  assign res_err   = res_err_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_freq_meas_sched.sv
// Scoreboard bench for freq_meas_sched with shrunk timing (PRE=4, GATE=9, POST=4, TMO=20).
module tb_freq_meas_sched;

  typedef struct packed {
    logic [1:0]  ch;
    logic [29:0] freq;
    logic        err;
  } res_t;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        run = 1'b0;
  logic [3:0]  ch_en = 4'b0;
  logic        core_done = 1'b0;
  logic [29:0] core_freq = '0;
  logic        res_ready = 1'b0;
  logic [1:0]  ch_sel;
  logic        core_clr;
  logic        gate;
  logic        res_valid;
  logic [1:0]  res_ch;
  logic [29:0] res_freq;
  logic        res_err;
  logic        busy;

  int   n_tests = 0;
  int   n_fail = 0;
  int   clr_cnt = 0;
  res_t sb_q[$];

  freq_meas_sched #(
    .CH_NUM      (4),
    .CH_W        (2),
    .PRE_CNT_MAX (4),
    .GATE_CNT_MAX(9),
    .POST_CNT_MAX(4),
    .FREQ_W      (30),
    .TMO_MAX     (20)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst  (sys_rst),
    .run      (run),
    .ch_en    (ch_en),
    .ch_sel   (ch_sel),
    .core_clr (core_clr),
    .gate     (gate),
    .core_done(core_done),
    .core_freq(core_freq),
    .res_valid(res_valid),
    .res_ready(res_ready),
    .res_ch   (res_ch),
    .res_freq (res_freq),
    .res_err  (res_err),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) if (core_clr === 1'b1) clr_cnt++;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    sys_rst = 1'b1; run = 1'b0; ch_en = 4'b0; res_ready = 1'b0; core_done = 1'b0;
    sb_q.delete();
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b0;
  endtask

  // Returns at the first negedge with gate low after a gate window.
  task automatic wait_gate(input bit drop_run, output int width, output logic [1:0] sel,
                           output bit sel_stable, output bit to);
    int n = 0;
    width = 0; sel = '0; sel_stable = 1'b1; to = 1'b0;
    while (gate !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
    if (gate !== 1'b1) begin to = 1'b1; return; end
    sel = ch_sel;
    if (drop_run) run = 1'b0;
    while (gate === 1'b1 && width < 100) begin
      if (ch_sel !== sel) sel_stable = 1'b0;
      width++;
      @(negedge sys_clk);
    end
  endtask

  // core_done lands in the 4th WAIT cycle (WAIT starts 5 cycles after gate falls).
  task automatic pulse_done(input logic [29:0] f);
    repeat (8) @(negedge sys_clk);
    core_freq = f; core_done = 1'b1;
    @(negedge sys_clk);
    core_done = 1'b0;
  endtask

  task automatic wait_valid(output bit to);
    int n = 0;
    while (res_valid !== 1'b1 && n < 200) begin @(negedge sys_clk); n++; end
    to = (res_valid !== 1'b1);
  endtask

  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (2) @(negedge sys_clk);
    n_tests++;
    if ({gate, core_clr, res_valid, res_err, busy} !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 00000", {gate, core_clr, res_valid, res_err, busy});
    end
    n_tests++;
    if ({ch_sel, res_ch, res_freq} !== 34'b0) begin
      n_fail++;
      $display("FAIL reset_data: got ch_sel=%0d res_ch=%0d res_freq=%0d want 0", ch_sel, res_ch,
               res_freq);
    end
    sys_rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_round_robin();
    int w; logic [1:0] s; bit st, to; res_t r; logic [1:0] exp_ch; int c0;
    do_reset();
    ch_en = 4'b0101; run = 1'b1; res_ready = 1'b1; c0 = clr_cnt;
    for (int i = 0; i < 3; i++) begin
      exp_ch = (i == 1) ? 2'd2 : 2'd0;
      wait_gate(1'b0, w, s, st, to);
      n_tests++;
      if (to || w != 10) begin n_fail++; $display("FAIL rr_gate_width: got %0d want 10", w); end
      n_tests++;
      if (s !== exp_ch || !st) begin
        n_fail++; $display("FAIL rr_ch_sel: got %0d stable=%0d want %0d", s, st, exp_ch);
      end
      sb_q.push_back({exp_ch, 30'd25_000_000, 1'b0});
      pulse_done(30'd25_000_000);
      wait_valid(to);
      if (i == 2) run = 1'b0;
      r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
      n_tests++;
      if (to || res_ch !== r.ch || res_freq !== r.freq || res_err !== r.err) begin
        n_fail++;
        $display("FAIL rr_result: got ch=%0d freq=%0d err=%b want ch=%0d freq=%0d err=%b",
                 res_ch, res_freq, res_err, r.ch, r.freq, r.err);
      end
      @(negedge sys_clk);
    end
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || clr_cnt - c0 != 3) begin
      n_fail++;
      $display("FAIL rr_end: busy=%b valid=%b clr=%0d want 0 0 3", busy, res_valid, clr_cnt - c0);
    end
  endtask

  task automatic test_no_channel();
    int c0;
    do_reset();
    ch_en = 4'b0000; run = 1'b1; c0 = clr_cnt;
    repeat (10) @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0 || clr_cnt != c0) begin
      n_fail++; $display("FAIL empty_idle: busy=%b clr=%0d want 0 0", busy, clr_cnt - c0);
    end
    ch_en = 4'b1000;
    @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b1 || core_clr !== 1'b1) begin
      n_fail++; $display("FAIL empty_pick: busy=%b clr=%b want 1 1", busy, core_clr);
    end
    @(negedge sys_clk);
    n_tests++;
    if (ch_sel !== 2'd3 || core_clr !== 1'b0) begin
      n_fail++; $display("FAIL empty_sel: ch_sel=%0d clr=%b want 3 0", ch_sel, core_clr);
    end
  endtask

  task automatic test_backpressure();
    int w; logic [1:0] s; bit st, to; res_t r; int c0;
    do_reset();
    ch_en = 4'b0001; run = 1'b1; res_ready = 1'b0;
    wait_gate(1'b0, w, s, st, to);
    sb_q.push_back({2'd0, 30'd123_456_789, 1'b0});
    pulse_done(30'd123_456_789);
    wait_valid(to);
    r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    c0 = clr_cnt;
    for (int k = 0; k < 7; k++) begin
      n_tests++;
      if (to || res_valid !== 1'b1 || res_ch !== r.ch || res_freq !== r.freq) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got valid=%b ch=%0d freq=%0d want 1 %0d %0d", k, res_valid,
                 res_ch, res_freq, r.ch, r.freq);
      end
      @(negedge sys_clk);
    end
    res_ready = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if (res_valid !== 1'b0 || core_clr !== 1'b1 || clr_cnt != c0) begin
      n_fail++;
      $display("FAIL bp_after: valid=%b clr=%b extra=%0d want 0 1 0", res_valid, core_clr,
               clr_cnt - c0);
    end
  endtask

  task automatic test_run_drop();
    int w; logic [1:0] s; bit st, to; res_t r; int c0;
    do_reset();
    ch_en = 4'b0010; run = 1'b1; res_ready = 1'b1;
    wait_gate(1'b1, w, s, st, to);
    n_tests++;
    if (to || w != 10 || s !== 2'd1) begin
      n_fail++; $display("FAIL drop_gate: width=%0d sel=%0d want 10 1", w, s);
    end
    sb_q.push_back({2'd1, 30'd777, 1'b0});
    pulse_done(30'd777);
    wait_valid(to);
    r = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
    n_tests++;
    if (to || res_ch !== r.ch || res_freq !== r.freq || res_err !== r.err) begin
      n_fail++;
      $display("FAIL drop_result: got ch=%0d freq=%0d want ch=%0d freq=%0d", res_ch, res_freq,
               r.ch, r.freq);
    end
    c0 = clr_cnt;
    repeat (10) @(negedge sys_clk);
    n_tests++;
    if (busy !== 1'b0 || res_valid !== 1'b0 || clr_cnt != c0) begin
      n_fail++;
      $display("FAIL drop_idle: busy=%b valid=%b clr=%0d want 0 0 0", busy, res_valid,
               clr_cnt - c0);
    end
  endtask

  task automatic test_mid_reset();
    int n = 0;
    do_reset();
    ch_en = 4'b1111; run = 1'b1; res_ready = 1'b1;
    while (gate !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
    n_tests++;
    if (gate !== 1'b1) begin n_fail++; $display("FAIL mrst_gate: gate=%b want 1", gate); end
    repeat (3) @(negedge sys_clk);
    sys_rst = 1'b1;
    @(negedge sys_clk);
    n_tests++;
    if (gate !== 1'b0 || res_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL mrst_out: gate=%b valid=%b busy=%b want 0 0 0", gate, res_valid, busy);
    end
    sys_rst = 1'b0;
    n = 0;
    while (core_clr !== 1'b1 && n < 20) begin @(negedge sys_clk); n++; end
    @(negedge sys_clk);
    n_tests++;
    if (n >= 20 || ch_sel !== 2'd0) begin
      n_fail++; $display("FAIL mrst_restart: ch_sel=%0d wait=%0d want 0", ch_sel, n);
    end
  endtask

  task automatic test_timeout();
    int w; logic [1:0] s; bit st, to; int n;
    do_reset();
    ch_en = 4'b0001; run = 1'b1; res_ready = 1'b0;
    wait_gate(1'b0, w, s, st, to);
`ifdef FREQ_SCHED_TMO_EN
    begin
      res_t r;
      sb_q.push_back({2'd0, 30'd0, 1'b1});
      n = 0;
      while (res_valid !== 1'b1 && n < 100) begin @(negedge sys_clk); n++; end
      r = sb_q.pop_front();
      n_tests++;
      if (to || n != 25) begin n_fail++; $display("FAIL tmo_time: got %0d want 25", n); end
      n_tests++;
      if (res_ch !== r.ch || res_freq !== r.freq || res_err !== r.err) begin
        n_fail++;
        $display("FAIL tmo_result: got ch=%0d freq=%0d err=%b want %0d %0d %b", res_ch,
                 res_freq, res_err, r.ch, r.freq, r.err);
      end
    end
`else
    n = 0;
    repeat (60) @(negedge sys_clk);
    n_tests++;
    if (to || res_valid !== 1'b0 || busy !== 1'b1 || res_err !== 1'b0) begin
      n_fail++;
      $display("FAIL tmo_wait: valid=%b busy=%b err=%b want 0 1 0", res_valid, busy, res_err);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_no_channel();
    test_backpressure();
    test_run_drop();
    test_mid_reset();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
